// File: rtl/sobel_gradient_pkg.sv
// Shared definitions for the Sobel gradient block: datapath widths, FSM
// encoding and the gradient scaling function.
// Build option: SOBEL_FULLSCALE_EN selects shift-by-1 with saturation
// instead of the default shift-by-2.
package sobel_gradient_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 9;
    localparam int ACC_W  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sobel_state_t;

    // Reduce an 11-bit kernel sum (range +/-1020) to the 9-bit output.
    function automatic logic signed [GRAD_W-1:0] scale_grad(input logic signed [ACC_W-1:0] acc);
`ifdef SOBEL_FULLSCALE_EN
        logic signed [ACC_W-1:0] half;
        half = acc >>> 1;
        if (half > 11'sd255)
            return 9'sb0_1111_1111;
        else if (half < -11'sd256)
            return 9'sb1_0000_0000;
        else
            return half[GRAD_W-1:0];
`else
        logic signed [ACC_W-1:0] quarter;
        quarter = acc >>> 2;
        return quarter[GRAD_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/sobel_gradient_if.sv
// Pixel-in / gradient-out stream bundle for sobel_gradient.
// master = pixel producer and gradient consumer, slave = the Sobel block.
interface sobel_gradient_if
    import sobel_gradient_pkg::*;
#(
    parameter int ADDRW = 24
) ();

    logic [PIX_W-1:0]         pixIn;
    logic                     pixValid;
    logic signed [GRAD_W-1:0] sobelX;
    logic signed [GRAD_W-1:0] sobelY;
    logic                     sobelValid;
    logic [ADDRW-1:0]         centreAddr;

    modport master (
        output pixIn, pixValid,
        input  sobelX, sobelY, sobelValid, centreAddr
    );

    modport slave (
        input  pixIn, pixValid,
        output sobelX, sobelY, sobelValid, centreAddr
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: single clock, independent write and
// registered read ports. A read and write to the same address in one cycle
// returns the old contents, which is what lets a line be replaced in place.
module sobel_line_buffer #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem_reg [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_reg[wr_addr] <= wr_data;
    end

    // Registered read port; data holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem_reg[rd_addr];
    end

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient generator. Accepts a raster pixel stream,
// keeps two previous lines in chained line buffers and emits one signed
// gradient pair per interior pixel, tagged with the centre address.
// Build option: SOBEL_FULLSCALE_EN (see sobel_gradient_pkg::scale_grad).
module sobel_gradient
    import sobel_gradient_pkg::*;
#(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 512,
    parameter int ADDRW = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startEn,
    output logic             busy,
    output logic             frameDone,
    sobel_gradient_if.slave  bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H) + 1;
    localparam logic [ADDRW-1:0] LAST_ADDR   = ADDRW'(IMG_W * IMG_H - 1);
    localparam logic [ADDRW-1:0] CENTRE_OFFS = ADDRW'(IMG_W + 1);

    sobel_state_t             state_reg;
    logic                     busy_reg, frame_done_reg;
    logic [COL_W-1:0]         col_reg, col_d_reg;
    logic [ROW_W-1:0]         row_reg, row_d_reg;
    logic [ADDRW-1:0]         addr_reg, addr_d_reg;
    logic                     acc_d_reg;
    logic [PIX_W-1:0]         pix_d_reg;
    logic                     accept, emit;

    // Window: index 0 = row r-2 (top), 1 = row r-1, 2 = row r (bottom).
    logic [PIX_W-1:0]         win1_reg [3];   // column c-1
    logic [PIX_W-1:0]         win2_reg [3];   // column c-2
    logic [PIX_W-1:0]         new_col  [3];   // column c, just read out
    logic [1:0][PIX_W-1:0]    lb_rd;
    logic [1:0][PIX_W-1:0]    lb_wr_data;
    logic [1:0][COL_W-1:0]    lb_wr_addr;
    logic [1:0]               lb_wr_en;
    logic signed [ACC_W-1:0]  gx_acc, gy_acc;

    logic signed [GRAD_W-1:0] sobel_x_reg, sobel_y_reg;
    logic                     sobel_valid_reg;
    logic [ADDRW-1:0]         centre_addr_reg;

    assign accept = (state_reg == RUN) && bus.pixValid;
    assign emit   = acc_d_reg && (row_d_reg >= ROW_W'(2)) && (col_d_reg >= COL_W'(2));

    // Line buffer 0 stores the incoming row; buffer 1 takes buffer 0's
    // read-out one cycle later, so both are read at column c on acceptance.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                assign lb_wr_en[gi]   = accept;
                assign lb_wr_addr[gi] = col_reg;
                assign lb_wr_data[gi] = bus.pixIn;
            end else begin : g_tail
                assign lb_wr_en[gi]   = acc_d_reg;
                assign lb_wr_addr[gi] = col_d_reg;
                assign lb_wr_data[gi] = lb_rd[gi-1];
            end
            sobel_line_buffer #(
                .DEPTH (IMG_W),
                .AW    (COL_W),
                .DW    (PIX_W)
            ) u_lb (
                .clk     (clk),
                .rd_en   (accept),
                .rd_addr (col_reg),
                .rd_data (lb_rd[gi]),
                .wr_en   (lb_wr_en[gi]),
                .wr_addr (lb_wr_addr[gi]),
                .wr_data (lb_wr_data[gi])
            );
        end
    endgenerate

    assign new_col[0] = lb_rd[1];
    assign new_col[1] = lb_rd[0];
    assign new_col[2] = pix_d_reg;

    // Frame FSM, position counters and the acceptance strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            col_reg        <= '0;
            row_reg        <= '0;
            addr_reg       <= '0;
            acc_d_reg      <= 1'b0;
        end else begin
            acc_d_reg      <= accept;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (startEn) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        col_reg   <= '0;
                        row_reg   <= '0;
                        addr_reg  <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        addr_reg <= addr_reg + 1'b1;
                        if (col_reg == COL_W'(IMG_W - 1)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                        if (addr_reg == LAST_ADDR) begin
                            state_reg      <= DONE;
                            busy_reg       <= 1'b0;
                            frame_done_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Capture the accepted pixel and its position for the next stage.
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_d_reg  <= bus.pixIn;
            col_d_reg  <= col_reg;
            row_d_reg  <= row_reg;
            addr_d_reg <= addr_reg;
        end
    end

    // Shift the 3x3 window left by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (acc_d_reg) begin
            for (int i = 0; i < 3; i++) begin
                win1_reg[i] <= new_col[i];
                win2_reg[i] <= win1_reg[i];
            end
        end
    end

    function automatic logic signed [ACC_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{(ACC_W - PIX_W){1'b0}}, p});
    endfunction

    // Kernel sums: right minus left (Gx) and bottom minus top (Gy), 1-2-1 weights.
    always_comb begin
        gx_acc = (ext(new_col[0]) - ext(win2_reg[0]))
               + ((ext(new_col[1]) - ext(win2_reg[1])) <<< 1)
               + (ext(new_col[2]) - ext(win2_reg[2]));
        gy_acc = (ext(win2_reg[2]) + (ext(win1_reg[2]) <<< 1) + ext(new_col[2]))
               - (ext(win2_reg[0]) + (ext(win1_reg[0]) <<< 1) + ext(new_col[0]));
    end

    // Output register: loads only for interior centres, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            sobel_x_reg     <= '0;
            sobel_y_reg     <= '0;
            sobel_valid_reg <= 1'b0;
            centre_addr_reg <= '0;
        end else begin
            sobel_valid_reg <= emit;
            if (emit) begin
                sobel_x_reg     <= scale_grad(gx_acc);
                sobel_y_reg     <= scale_grad(gy_acc);
                centre_addr_reg <= addr_d_reg - CENTRE_OFFS;
            end
        end
    end

    assign bus.sobelX     = sobel_x_reg;
    assign bus.sobelY     = sobel_y_reg;
    assign bus.sobelValid = sobel_valid_reg;
    assign bus.centreAddr = centre_addr_reg;
    assign busy           = busy_reg;
    assign frameDone      = frame_done_reg;

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed bench for sobel_gradient on an 8x6 image: hand-computed edge
// images, a direct-convolution reference for random images, pixValid gaps,
// idle/run input filtering, latency, frameDone and mid-frame reset.
module tb_sobel_gradient;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = 24;
`ifdef SOBEL_FULLSCALE_EN
    localparam int EDGE_V = 255;    // 800 >>> 1 = 400, saturated
    localparam int EDGE_H = -256;   // -800 >>> 1 = -400, saturated
`else
    localparam int EDGE_V = 200;    // 800 >>> 2
    localparam int EDGE_H = -200;   // -800 >>> 2
`endif

    logic clk = 1'b0;
    logic reset, startEn, busy, frameDone;

    sobel_gradient_if #(.ADDRW(AW)) bus ();

    sobel_gradient #(.IMG_W(W), .IMG_H(H), .ADDRW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .startEn   (startEn),
        .busy      (busy),
        .frameDone (frameDone),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int img [N];
    int exp_x[$], exp_y[$], exp_a[$];
    int got_x[$], got_y[$], got_a[$];
    int first_out_cyc, done_cyc, done_cnt, acc18_cyc, last_acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect outputs away from the active edge.
    always @(negedge clk) begin
        if (bus.sobelValid === 1'b1) begin
            if (got_x.size() == 0) first_out_cyc = cyc;
            got_x.push_back(int'($signed(bus.sobelX)));
            got_y.push_back(int'($signed(bus.sobelY)));
            got_a.push_back(int'(bus.centreAddr));
        end
        if (frameDone === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int scale_ref(input int g);
`ifdef SOBEL_FULLSCALE_EN
        int h;
        h = g >>> 1;
        if (h > 255) h = 255;
        if (h < -256) h = -256;
        return h;
`else
        return g >>> 2;
`endif
    endfunction

    function automatic int px(input int r, input int c);
        return img[r * W + c];
    endfunction

    task automatic clear_exp();
        exp_x.delete(); exp_y.delete(); exp_a.delete();
    endtask

    task automatic push_exp(input int x, input int y, input int a);
        exp_x.push_back(x); exp_y.push_back(y); exp_a.push_back(a);
    endtask

    // Reference outputs by direct 3x3 convolution over the stored image.
    task automatic build_ref();
        int gx, gy;
        clear_exp();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                gx = (px(r-1,c+1) - px(r-1,c-1)) + 2 * (px(r,c+1) - px(r,c-1))
                   + (px(r+1,c+1) - px(r+1,c-1));
                gy = (px(r+1,c-1) + 2 * px(r+1,c) + px(r+1,c+1))
                   - (px(r-1,c-1) + 2 * px(r-1,c) + px(r-1,c+1));
                push_exp(scale_ref(gx), scale_ref(gy), r * W + c);
            end
        end
    endtask

    // Junk pixels while idle, a start pulse, then the frame (optional gaps).
    task automatic run_frame(input bit gaps);
        int i;
        got_x.delete(); got_y.delete(); got_a.delete();
        done_cnt = 0; done_cyc = -1; first_out_cyc = -1;
        repeat (3) begin
            bus.pixValid = 1'b1; bus.pixIn = 8'hA5;
            @(negedge clk);
        end
        bus.pixValid = 1'b0;
        startEn = 1'b1;
        @(negedge clk);
        startEn = 1'b0;
        i = 0;
        while (i < N) begin
            startEn = (i == 10);
            if (gaps && $urandom_range(0, 99) < 30) begin
                bus.pixValid = 1'b0;
                bus.pixIn    = 8'h5A;
            end else begin
                bus.pixValid = 1'b1;
                bus.pixIn    = 8'(img[i]);
                if (i == 18)    acc18_cyc    = cyc + 1;
                if (i == N - 1) last_acc_cyc = cyc + 1;
                i++;
            end
            @(negedge clk);
        end
        startEn = 1'b0;
        bus.pixValid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic compare_frame(input string name);
        int n;
        check({name, " count"}, got_x.size(), exp_x.size());
        n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s x[%0d]", name, k), got_x[k], exp_x[k]);
            check($sformatf("%s y[%0d]", name, k), got_y[k], exp_y[k]);
            check($sformatf("%s addr[%0d]", name, k), got_a[k], exp_a[k]);
        end
        check({name, " frameDone count"}, done_cnt, 1);
        check({name, " frameDone cycle"}, done_cyc, last_acc_cyc);
        check({name, " first output cycle"}, first_out_cyc, acc18_cyc + 1);
        check({name, " busy after frame"}, int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; startEn = 1'b1;
        bus.pixValid = 1'b0; bus.pixIn = '0;
        repeat (3) @(negedge clk);
        check("reset sobelValid", int'(bus.sobelValid), 0);
        check("reset sobelX", int'($signed(bus.sobelX)), 0);
        check("reset sobelY", int'($signed(bus.sobelY)), 0);
        check("reset centreAddr", int'(bus.centreAddr), 0);
        check("reset busy", int'(busy), 0);
        check("reset frameDone", int'(frameDone), 0);
        reset = 1'b0; startEn = 1'b0;
        @(negedge clk);
        check("idle after reset", int'(busy), 0);

        // Uniform 100: every gradient zero.
        for (int i = 0; i < N; i++) img[i] = 100;
        clear_exp();
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++)
                push_exp(0, 0, r * W + c);
        run_frame(1'b0);
        compare_frame("uniform");

        // Vertical edge: columns 0-3 = 0, 4-7 = 200.
        for (int i = 0; i < N; i++) img[i] = ((i % W) >= 4) ? 200 : 0;
        clear_exp();
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++)
                push_exp((c == 3 || c == 4) ? EDGE_V : 0, 0, r * W + c);
        run_frame(1'b0);
        compare_frame("vedge");

        // Horizontal edge: rows 0-2 = 200, rows 3-5 = 0.
        for (int i = 0; i < N; i++) img[i] = ((i / W) <= 2) ? 200 : 0;
        clear_exp();
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++)
                push_exp(0, (r == 2 || r == 3) ? EDGE_H : 0, r * W + c);
        run_frame(1'b0);
        compare_frame("hedge");

        // Random image with ~30% pixValid gaps.
        for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
        build_ref();
        run_frame(1'b1);
        compare_frame("random gaps");

        // Reset after pixel 20 is accepted; its output is in flight.
        for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
        startEn = 1'b1;
        @(negedge clk);
        startEn = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            bus.pixValid = 1'b1; bus.pixIn = 8'(img[i]);
            @(negedge clk);
        end
        reset = 1'b1; startEn = 1'b1; bus.pixIn = 8'(img[21]);
        @(negedge clk);
        check("midreset sobelValid", int'(bus.sobelValid), 0);
        check("midreset busy", int'(busy), 0);
        reset = 1'b0; startEn = 1'b0; bus.pixValid = 1'b0;
        @(negedge clk);
        check("midreset stays idle", int'(busy), 0);
        build_ref();
        run_frame(1'b1);
        compare_frame("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
